// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises valid/ready bitstream words LSB-first onto ccff_head.
// Optional CCFF_CHAIN_LOADER_READBACK_EN adds a CRC-16-CCITT over ccff_tail as readback_crc.
module ccff_chain_loader #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CHAIN_LEN  = 64,
    parameter int unsigned CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    input  logic                  ccff_tail,
    output logic                  prog_clk_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  bit_count
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    ,
    output logic [15:0]           readback_crc
`endif
);

    localparam int unsigned LW = $clog2(WORD_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [LW-1:0]         left_q, left_d;
    logic [CNT_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  head_q, head_d;
    logic                  en_q, en_d;
    logic                  accept;
    int unsigned           remaining;
    int unsigned           take;

    always_comb begin
        remaining = CHAIN_LEN - 32'(acc_q);
        // Final word may be partial: only the bits the chain still needs are counted and shifted.
        take      = (remaining < WORD_WIDTH) ? remaining : WORD_WIDTH;
        cfg_ready = (state_q == StLoad) && (32'(acc_q) < CHAIN_LEN) &&
                    ((left_q == '0) || ((left_q == LW'(1)) && en_q));
        accept    = cfg_ready && cfg_valid;

        state_d = state_q;
        shift_d = shift_q;
        left_d  = left_q;
        acc_d   = acc_q;
        count_d = count_q;
        head_d  = head_q;
        en_d    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    left_d  = '0;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            StLoad: begin
                if (en_q) begin
                    count_d = count_q + CNT_WIDTH'(1);
                    left_d  = left_q - LW'(1);
                    if (32'(count_q) + 32'd1 == CHAIN_LEN) begin
                        state_d = StDone;
                    end
                end
                if (accept) begin
                    head_d  = cfg_data[0];
                    shift_d = cfg_data >> 1;
                    left_d  = LW'(take);
                    acc_d   = CNT_WIDTH'(32'(acc_q) + take);
                    en_d    = 1'b1;
                end else if (en_q && (left_q > LW'(1))) begin
                    head_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    en_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= StIdle;
            shift_q <= '0;
            left_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            left_q  <= left_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            head_q  <= head_d;
            en_q    <= en_d;
        end
    end

    assign ccff_head   = head_q;
    assign prog_clk_en = en_q;
    assign busy        = (state_q == StLoad);
    assign done        = (state_q == StDone);
    assign bit_count   = count_q;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (start && (state_q != StLoad)) begin
            crc_d = 16'hFFFF;
        end else if (en_q) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ({16{crc_q[15] ^ ccff_tail}} & 16'h1021);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign readback_crc = crc_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 64-bit chain instance and a 12-bit partial-word instance.
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic       pReset;
    logic       start_a, valid_a, ready_a, head_a, tail_a, en_a, busy_a, done_a;
    logic [7:0] data_a;
    logic [6:0] count_a;
    logic       start_b, valid_b, ready_b, head_b, tail_b, en_b, busy_b, done_b;
    logic [7:0] data_b;
    logic [3:0] count_b;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    logic [15:0] crc_a, crc_b;
`endif

    int errors = 0;
    int checks = 0;

    ccff_chain_loader #(.WORD_WIDTH(8), .CHAIN_LEN(64)) dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .cfg_data(data_a),
        .cfg_valid(valid_a), .cfg_ready(ready_a), .ccff_head(head_a), .ccff_tail(tail_a),
        .prog_clk_en(en_a), .busy(busy_a), .done(done_a), .bit_count(count_a)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        , .readback_crc(crc_a)
`endif
    );

    ccff_chain_loader #(.WORD_WIDTH(8), .CHAIN_LEN(12)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .cfg_data(data_b),
        .cfg_valid(valid_b), .cfg_ready(ready_b), .ccff_head(head_b), .ccff_tail(tail_b),
        .prog_clk_en(en_b), .busy(busy_b), .done(done_b), .bit_count(count_b)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        , .readback_crc(crc_b)
`endif
    );

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic test_reset();
        pReset = 1'b1;
        step();
        step();
        checks++;
        if ({ready_a, head_a, en_a, busy_a, done_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs_a: got %b want 00000",
                     {ready_a, head_a, en_a, busy_a, done_a});
        end
        checks++;
        if (count_a !== 7'd0) begin
            errors++;
            $display("FAIL reset_count_a: got %0d want 0", count_a);
        end
        checks++;
        if ({ready_b, head_b, en_b, busy_b, done_b, count_b} !== 9'b0) begin
            errors++;
            $display("FAIL reset_b: got %b want 0", {ready_b, head_b, en_b, busy_b, done_b, count_b});
        end
        pReset = 1'b0;
        step();
        checks++;
        if (busy_a !== 1'b0 || ready_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b ready=%b want 0 0", busy_a, ready_a);
        end
    endtask

    // Feeds words 0x01..0x08 into dut_a, checking every shifted bit and the count alongside it.
    task automatic run_load_a(input bit stall, input bit mid_start);
        int  n = 0;
        int  word = 0;
        int  first = -1;
        int  last = -1;
        int  stall_cycles = 0;
        int  w;
        bit  acc;
        logic e;
        data_a  = 8'd1;
        valid_a = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            acc = ready_a && valid_a;
            step();
            start_a = 1'b0;
            if (acc) begin
                word++;
                if (word == 8) begin
                    valid_a = 1'b0;
                    checks++;
                    if (ready_a !== 1'b0) begin
                        errors++;
                        $display("FAIL ready_after_last: got %b want 0", ready_a);
                    end
                end else begin
                    data_a = 8'(word + 1);
                end
                if (stall && word == 3) valid_a = 1'b0;
            end
            if (en_a) begin
                w = n / 8 + 1;
                e = ((w >> (n % 8)) & 1) != 0;
                checks++;
                if (head_a !== e || count_a !== 7'(n)) begin
                    errors++;
                    $display("FAIL shift[%0d]: head=%b count=%0d want head=%b count=%0d",
                             n, head_a, count_a, e, n);
                end
                if (first < 0) first = cyc;
                last = cyc;
                n++;
                if (mid_start && n == 20) start_a = 1'b1;
            end else if (n == 64) begin
                break;
            end else if (stall && n == 24) begin
                stall_cycles++;
                checks++;
                if (count_a !== 7'd24 || head_a !== 1'b0 || busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: count=%0d head=%b busy=%b want 24 0 1",
                             count_a, head_a, busy_a);
                end
                if (stall_cycles == 5) valid_a = 1'b1;
            end
        end
        valid_a = 1'b0;
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL enable_count: got %0d want 64", n);
        end
        if (!stall) begin
            checks++;
            if (last - first + 1 != 64) begin
                errors++;
                $display("FAIL enable_consecutive: span %0d want 64", last - first + 1);
            end
        end else begin
            checks++;
            if (stall_cycles != 5) begin
                errors++;
                $display("FAIL stall_cycles: got %0d want 5", stall_cycles);
            end
        end
        checks++;
        if (done_a !== 1'b1 || count_a !== 7'd64 || en_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL done_after_64: done=%b count=%0d en=%b busy=%b want 1 64 0 0",
                     done_a, count_a, en_a, busy_a);
        end
        step();
        step();
        checks++;
        if (done_a !== 1'b1 || count_a !== 7'd64) begin
            errors++;
            $display("FAIL done_hold: done=%b count=%0d want 1 64", done_a, count_a);
        end
    endtask

    task automatic test_full_load();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || count_a !== 7'd0 || ready_a !== 1'b1) begin
            errors++;
            $display("FAIL start_from_idle: busy=%b count=%0d ready=%b want 1 0 1",
                     busy_a, count_a, ready_a);
        end
        run_load_a(1'b0, 1'b1);
    endtask

    task automatic test_restart_stall();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1 || count_a !== 7'd0) begin
            errors++;
            $display("FAIL start_from_done: done=%b busy=%b count=%0d want 0 1 0",
                     done_a, busy_a, count_a);
        end
        run_load_a(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit acc;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        data_a  = 8'd1;
        valid_a = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            acc = ready_a && valid_a;
            step();
            if (acc) data_a = data_a + 8'd1;
            if (count_a == 7'd30) break;
        end
        checks++;
        if (count_a !== 7'd30) begin
            errors++;
            $display("FAIL reach_30: got %0d want 30", count_a);
        end
        pReset  = 1'b1;
        valid_a = 1'b0;
        step();
        pReset  = 1'b0;
        checks++;
        if ({ready_a, head_a, en_a, busy_a, done_a} !== 5'b0 || count_a !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_load: outs=%b count=%0d want 00000 0",
                     {ready_a, head_a, en_a, busy_a, done_a}, count_a);
        end
        step();
        checks++;
        if (busy_a !== 1'b0 || en_a !== 1'b0) begin
            errors++;
            $display("FAIL stay_idle: busy=%b en=%b want 0 0", busy_a, en_a);
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        data_a  = 8'h01;
        valid_a = 1'b1;
        checks++;
        if (busy_a !== 1'b1 || count_a !== 7'd0) begin
            errors++;
            $display("FAIL restart: busy=%b count=%0d want 1 0", busy_a, count_a);
        end
        step();
        valid_a = 1'b0;
        checks++;
        if (en_a !== 1'b1 || head_a !== 1'b1 || count_a !== 7'd0) begin
            errors++;
            $display("FAIL restart_first_bit: en=%b head=%b count=%0d want 1 1 0",
                     en_a, head_a, count_a);
        end
    endtask

    task automatic test_partial_word();
        logic [11:0] exp_bits;
        int  n = 0;
        int  words = 0;
        bit  acc;
        exp_bits = 12'b1100_1010_0101;
        start_b  = 1'b1;
        step();
        start_b  = 1'b0;
        data_b   = 8'hA5;
        valid_b  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = ready_b && valid_b;
            step();
            if (acc) begin
                words++;
                data_b = (words == 1) ? 8'h3C : 8'hFF;
                if (words == 2) begin
                    checks++;
                    if (ready_b !== 1'b0) begin
                        errors++;
                        $display("FAIL ready_after_partial: got %b want 0", ready_b);
                    end
                end
            end
            if (en_b) begin
                if (n < 12) begin
                    checks++;
                    if (head_b !== exp_bits[n]) begin
                        errors++;
                        $display("FAIL partial_bit[%0d]: got %b want %b", n, head_b, exp_bits[n]);
                    end
                end
                n++;
            end
        end
        valid_b = 1'b0;
        checks++;
        if (n != 12 || words != 2) begin
            errors++;
            $display("FAIL partial_count: enables=%0d words=%0d want 12 2", n, words);
        end
        checks++;
        if (done_b !== 1'b1 || count_b !== 4'd12 || en_b !== 1'b0) begin
            errors++;
            $display("FAIL partial_done: done=%b count=%0d en=%b want 1 12 0",
                     done_b, count_b, en_b);
        end
    endtask

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    task automatic test_readback();
        logic [15:0] model;
        model = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            model = {model[14:0], 1'b0} ^ ({16{model[15]}} & 16'h1021);
        end
        pReset = 1'b1;
        step();
        pReset = 1'b0;
        checks++;
        if (crc_a !== 16'hFFFF) begin
            errors++;
            $display("FAIL crc_reset: got %h want ffff", crc_a);
        end
        tail_a  = 1'b0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_load_a(1'b0, 1'b0);
        checks++;
        if (crc_a !== model) begin
            errors++;
            $display("FAIL crc_zeros: got %h want %h", crc_a, model);
        end
        tail_a = 1'b1;
        step();
        step();
        checks++;
        if (crc_a !== model) begin
            errors++;
            $display("FAIL crc_frozen: got %h want %h", crc_a, model);
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if (crc_a !== 16'hFFFF) begin
            errors++;
            $display("FAIL crc_start_clear: got %h want ffff", crc_a);
        end
        tail_a = 1'b0;
    endtask
`endif

    initial begin
        pReset  = 1'b1;
        start_a = 1'b0;
        valid_a = 1'b0;
        data_a  = 8'h00;
        tail_a  = 1'b0;
        start_b = 1'b0;
        valid_b = 1'b0;
        data_b  = 8'h00;
        tail_b  = 1'b0;
        test_reset();
        test_full_load();
        test_restart_stall();
        test_reset_mid();
        test_partial_word();
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Upstream configuration-chain driver for the I/O and logic grid tiles.
- Accepts parallel bitstream words over a valid/ready interface and serialises them LSB-first onto the tile chain's ccff_head.
- Emits a per-cycle shift enable that gates the chain clock, so the chain advances only on valid bits.
- Counts shifted bits and flags completion once exactly CHAIN_LEN bits are loaded.

Parameters:
- WORD_WIDTH, 8, bits per input word.
- CHAIN_LEN, 64, total configuration bits in the downstream chain (>=1).
- CNT_WIDTH, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- prog_clk  input  1  programming clock; all state updates on rising edge.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE or DONE.
- cfg_data  input  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts the word this cycle.
- ccff_head  output  1  serial bit to the first tile's ccff_head.
- ccff_tail  input  1  serial bit from the last tile's ccff_tail.
- prog_clk_en  output  1  chain shift enable to the tile-chain clock gate.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- bit_count  output  CNT_WIDTH  bits shifted so far in the current load.

Behaviour:
- Reset: pReset=1 at an edge forces state IDLE. Cleared to 0: cfg_ready, ccff_head, prog_clk_en, busy, done, bit_count, the internal shift register, the word-bits-left counter and the accepted-bits counter.
- Reset mid-LOAD aborts the load; the chain contents are undefined, and a fresh start is required.
- States:
  - IDLE: start -> LOAD; all counters clear on entry.
  - LOAD: bit_count reaching CHAIN_LEN -> DONE.
  - DONE: start -> LOAD with counters cleared.
- start is ignored in LOAD.
- Word acceptance: handshake completes when cfg_valid & cfg_ready at an edge. cfg_ready is combinational and high only when all of:
  - state is LOAD;
  - accepted-bits < CHAIN_LEN;
  - word-bits-left == 0, or word-bits-left == 1 with prog_clk_en == 1 (allows back-to-back words with no bubble).
- Latency: a word accepted at edge N drives its bit 0 on ccff_head with prog_clk_en=1 in the cycle after N.
- Each cycle with prog_clk_en=1: shift register moves right by one, bit_count += 1, word-bits-left -= 1.
- Both ccff_head and prog_clk_en are registered outputs.
- Starvation: when word-bits-left is 0 and no word is accepted, prog_clk_en=0. ccff_head holds its last value; bit_count is unchanged.
- Partial last word: accepted-bits advances by min(WORD_WIDTH, CHAIN_LEN - accepted-bits). The surplus upper bits of the final word are discarded and never shifted. prog_clk_en pulses exactly CHAIN_LEN times per load.
- Completion: on the edge where bit_count becomes CHAIN_LEN, state goes to DONE and prog_clk_en goes 0 in the following cycle. done=1 and bit_count holds CHAIN_LEN until the next start or pReset.
- ccff_tail is ignored in the base build.

Optional Feature:
- Macro CCFF_CHAIN_LOADER_READBACK_EN.
- Defined:
  - Adds output port readback_crc [15:0].
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first update) over the ccff_tail value sampled on every cycle with prog_clk_en=1.
  - Cleared to 0xFFFF on pReset and on start; frozen in DONE.
  - Lets software verify that the previous chain contents shifted out intact.
- Undefined: no readback_crc port, no CRC logic; ccff_tail is unused.

Test Plan:
- CHAIN_LEN=64, WORD_WIDTH=8: start, then 8 words 0x01..0x08 with cfg_valid held high -> prog_clk_en high for exactly 64 consecutive cycles; ccff_head sequence equals the words LSB-first; done=1 with bit_count=64 one edge after the 64th shift; cfg_ready=0 after the 8th word.
- Stall: drop cfg_valid for 5 cycles after word 3 -> prog_clk_en=0 for those 5 cycles, bit_count frozen at 24, ccff_head unchanged; resumes with word 4 bit 0.
- CHAIN_LEN=12: send words 0xA5 and 0x3C -> exactly 12 enables; sequence 1,0,1,0,0,1,0,1,0,0,1,1; bits 4-7 of 0x3C are never driven.
- pReset asserted at bit_count=30 -> next cycle state IDLE, all outputs 0; start after release restarts at bit_count=0.
- start pulsed in mid-LOAD -> ignored, count continues. start pulsed in DONE -> done clears, new load begins.
- READBACK_EN: drive ccff_tail with 64 zeros -> readback_crc matches the golden CRC-16-CCITT of 64 zero bits; pReset -> 0xFFFF.
